// File: rtl/cdb_arbiter_pkg.sv
// Shared common-data-bus constants and payload types used by the arbiter,
// the reservation stations and the ROB.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_CDB_ENTRIES = 4;
    localparam int unsigned CDB_NUM_SRC     = 8;
    localparam int unsigned CDB_TAG_W       = 3;
    localparam int unsigned CDB_DATA_W      = 32;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
    } cdb_entry_t;

    typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
    } cdb_src_t;

endpackage

// File: rtl/cdb_arbiter_rr_multi_picker.sv
// Combinational k-of-n rotating-priority selector: grants up to K requesters
// scanning from start_i, and reports which requester landed in each slot.
module cdb_arbiter_rr_multi_picker #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 4
) (
    input  logic [N-1:0]                    req_i,
    input  logic [$clog2(N)-1:0]            start_i,
    output logic [N-1:0]                    grant_o,
    output logic [K-1:0]                    slot_valid_o,
    output logic [K-1:0][$clog2(N)-1:0]     slot_idx_o,
    output logic [$clog2(N)-1:0]            last_o,
    output logic                            any_o
);

    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned SLOT_W = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CNT_W  = SLOT_W + 1;

    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    // Walk the ring once from start_i; the j-th hit goes to slot j.
    always_comb begin
        grant_o      = '0;
        slot_valid_o = '0;
        slot_idx_o   = '0;
        last_o       = '0;
        idx          = '0;
        cnt          = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDX_W'((32'(start_i) + k) % N);
            if (req_i[idx] && (cnt < CNT_W'(K))) begin
                grant_o[idx]                    = 1'b1;
                slot_valid_o[cnt[SLOT_W-1:0]]   = 1'b1;
                slot_idx_o[cnt[SLOT_W-1:0]]     = idx;
                last_o                          = idx;
                cnt                             = cnt + CNT_W'(1);
            end
        end
        any_o = |grant_o;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry hold per result source, round-robin
// grant of up to NUM_CDB holds per cycle onto a registered broadcast bundle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = CDB_NUM_SRC,
    parameter int unsigned NUM_CDB = NUM_CDB_ENTRIES,
    parameter int unsigned TAG_W   = CDB_TAG_W,
    parameter int unsigned DATA_W  = CDB_DATA_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [NUM_SRC-1:0]               src_valid_i,
    input  logic [NUM_SRC-1:0][TAG_W-1:0]    src_tag_i,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]   src_value_i,
    output logic [NUM_SRC-1:0]               src_ready_o,
    output logic [NUM_CDB-1:0]               cdb_valid_o,
    output logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag_o,
    output logic [NUM_CDB-1:0][DATA_W-1:0]   cdb_value_o
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    cdb_src_t [NUM_SRC-1:0] hold_q, hold_d;
    cdb_t                   cdb_q, cdb_d;
    logic [IDX_W-1:0]       rr_q, rr_d;

    logic [NUM_SRC-1:0]            held;
    logic [NUM_SRC-1:0]            grant;
    logic [NUM_CDB-1:0]            slot_valid;
    logic [NUM_CDB-1:0][IDX_W-1:0] slot_idx;
    logic [IDX_W-1:0]              last_idx;
    logic                          any_grant;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            held[i] = hold_q[i].valid;
        end
    end

    // Grant depends only on registered state, so ready never loops back to valid.
    cdb_arbiter_rr_multi_picker #(
        .N (NUM_SRC),
        .K (NUM_CDB)
    ) u_picker (
        .req_i        (held),
        .start_i      (rr_q),
        .grant_o      (grant),
        .slot_valid_o (slot_valid),
        .slot_idx_o   (slot_idx),
        .last_o       (last_idx),
        .any_o        (any_grant)
    );

    assign src_ready_o = (rst || flush) ? '0 : (~held | grant);

    always_comb begin
        hold_d = hold_q;
        cdb_d  = '0;
        rr_d   = rr_q;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (slot_valid[k]) begin
                cdb_d[k].valid = 1'b1;
                cdb_d[k].tag   = hold_q[slot_idx[k]].tag;
                cdb_d[k].value = hold_q[slot_idx[k]].value;
            end
        end
        // A refill in the same cycle as the grant takes precedence over the clear.
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                hold_d[i].valid = 1'b0;
            end
            if (src_valid_i[i] && src_ready_o[i]) begin
                hold_d[i].valid = 1'b1;
                hold_d[i].tag   = src_tag_i[i];
                hold_d[i].value = src_value_i[i];
            end
        end
        if (any_grant) begin
            rr_d = IDX_W'((32'(last_idx) + 32'd1) % NUM_SRC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold_q <= '0;
            cdb_q  <= '0;
            rr_q   <= '0;
        end else begin
            hold_q <= hold_d;
            cdb_q  <= cdb_d;
            rr_q   <= rr_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            cdb_valid_o[k] = cdb_q[k].valid;
            cdb_tag_o[k]   = cdb_q[k].tag;
            cdb_value_o[k] = cdb_q[k].value;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Back end of the reservation-station result path: collects finished results (ROB tag + value) from all functional-unit RS slots (ALU, CMP, load) and drives the common data bus.
- Per-source one-entry holding registers with valid/ready handshake.
- Round-robin grants of up to NUM_CDB sources per cycle.
- Broadcasts a registered cdb bundle that every RS and the ROB snoop.

Parameters:
- NUM_SRC, 8: number of result producers (RS slots / units) feeding the bus.
- NUM_CDB, 4: broadcast slots per cycle (equals the shared NUM_CDB_ENTRIES constant).
- TAG_W, 3: ROB index width (log2 of RO_BUFFER_ENTRIES).
- DATA_W, 32: result width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; discards all pending results.
- src_valid_i  in  NUM_SRC  source i presents a result.
- src_tag_i  in  NUM_SRC x TAG_W  ROB tag per source.
- src_value_i  in  NUM_SRC x DATA_W  result value per source.
- src_ready_o  out  NUM_SRC  arbiter accepts source i this cycle.
- cdb_valid_o  out  NUM_CDB  broadcast slot k carries a result.
- cdb_tag_o  out  NUM_CDB x TAG_W  tag on slot k.
- cdb_value_o  out  NUM_CDB x DATA_W  value on slot k.

Behaviour:
- State:
  - held[i], hold_tag[i], hold_val[i] per source.
  - rr_ptr (log2 NUM_SRC bits).
  - Registered cdb outputs.
- Handshake:
  - Transfer occurs when src_valid_i[i] && src_ready_o[i] at a rising edge; the result is captured into hold i.
  - Source must hold tag/value stable while valid && !ready.
- Grant, combinational, from held[] and rr_ptr only (never from src_valid_i, so no loop):
  - Scan sources in order rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - The first min(NUM_CDB, popcount(held)) held sources are granted.
  - The j-th granted source (in scan order) maps to slot j.
- src_ready_o[i] = !flush && (!held[i] || grant[i]):
  - Allows one result per source per cycle at steady state.
- Edge after grant:
  - cdb slot j <= {1, hold_tag, hold_val} of its granted source.
  - Ungranted slots <= valid 0, tag 0, value 0.
  - held[i] cleared unless refilled in the same cycle; refill wins.
- Latency: result accepted in cycle t, broadcast visible in cycle t+2. No same-cycle bypass.
- rr_ptr update:
  - If any grant: rr_ptr <= (index of last granted source + 1) mod NUM_SRC.
  - Otherwise unchanged.
- cdb outputs are one-cycle pulses; a slot holds valid for exactly one cycle per result.
- Duplicate tags across sources are not checked; both are broadcast. Tag 0 is a legal tag.
- Full condition: all held and no grant possible to a source means ready 0; source stalls. A held result is never dropped or reordered per source.
- flush (rst has identical effect):
  - Clears every held bit and all cdb slots.
  - rr_ptr <= 0.
  - Inputs in the flush cycle are not captured (ready forced 0).
  - Grants computed in the flush cycle are discarded.
  - In the cycle after flush, cdb_valid_o is all 0.
- Reset values: cdb_valid_o 0, cdb_tag_o 0, cdb_value_o 0, rr_ptr 0, held 0. src_ready_o is all 1 in the first cycle after reset deasserts.
- Reset mid-operation: pending results are lost with no broadcast.

Decomposition:
- Shared package (structs):
  - cdb_entry_t {valid, tag, value}.
  - cdb_t = cdb_entry_t array of NUM_CDB_ENTRIES.
  - cdb_src_t {valid, tag, value}.
- Shared macros: NUM_CDB_ENTRIES, CDB_NUM_SRC.
- Sub-module rr_multi_picker:
  - Combinational k-of-n rotating priority selector.
  - Inputs: req vector, start pointer.
  - Outputs: grant vector, per-slot source index/valid, last-granted index.
  - Unit-testable on its own.

Test Plan:
- Reset: hold rst 2 cycles, release -> cdb_valid_o=0000, all tags/values 0, src_ready_o=0xFF.
- Single result: src 3 valid in cycle 0, tag 5, value 0xDEADBEEF -> cycle 2: slot0 valid, tag 5, value 0xDEADBEEF; slots 1-3 invalid; cycle 3: all invalid.
- Oversubscription: sources 0-7 valid in cycle 0, distinct tags 0-7 ->
  - Cycle 2: slots carry src 0,1,2,3.
  - Cycle 3: slots carry src 4,5,6,7.
  - src_ready_o[7:4]=0 in cycle 1.
  - rr_ptr=0 after cycle 2.
- Round robin: sources 0-5 continuously valid -> grant sets {0,1,2,3}, {4,5,0,1}, {2,3,4,5}; no source starves.
- Back-to-back single source: src 2 valid every cycle with tags 1,2,3,4 -> ready stays 1; slot0 shows tags 1,2,3,4 in consecutive cycles from cycle 2.
- Flush/reset mid-flight: fill 8 holds, assert flush in cycle 1 -> no cdb_valid in cycles 2-3; src 6 presenting in the flush cycle is not captured (ready 0); repeat with rst -> same result.
